// File: rtl/regfile_fifo_ctrl_pkg.sv
// Shared widths and handshake types for the regfile-backed FIFO controller.
// Defines `A_WIDTH, `D_WIDTH, `FIFO_DEPTH; optional feature macro: FIFO_LEVEL_EN.
`ifndef REGFILE_FIFO_DEFINES
`define REGFILE_FIFO_DEFINES
`ifndef A_WIDTH
`define A_WIDTH 2
`endif
`ifndef D_WIDTH
`define D_WIDTH 32
`endif
`define FIFO_DEPTH (2**`A_WIDTH)
`endif

package regfile_fifo_ctrl_pkg;
  localparam int AF_LVL_DEF = 3;

  typedef struct packed {
    logic push;
    logic pop;
  } fifo_hs_t;

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_stat_t;
endpackage

// File: rtl/regfile_fifo_ctrl_fifo_ptr.sv
// Wrapping A_WIDTH-bit FIFO pointer; overflow wraps naturally at 2**W.
module fifo_ptr #(
  parameter int W = 2
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  always_ff @(posedge Clk) begin
    if (Rst)      ptr <= '0;
    else if (inc) ptr <= ptr + W'(1);
  end
endmodule

// File: rtl/regfile_fifo_ctrl.sv
// FIFO controller using an external register file as storage; owns pointers, count and handshake.
// FIFO_LEVEL_EN adds registered Level and Almost_Full outputs.
module regfile_fifo_ctrl
  import regfile_fifo_ctrl_pkg::*;
#(
  parameter int A_WIDTH = `A_WIDTH,
  parameter int D_WIDTH = `D_WIDTH,
  parameter int AF_LVL  = AF_LVL_DEF
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [D_WIDTH-1:0] In_Data,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [D_WIDTH-1:0] Out_Data,
  output logic [A_WIDTH-1:0] R_Addr,
  output logic               R_en,
  input  logic [D_WIDTH-1:0] R_Data,
  output logic [A_WIDTH-1:0] W_Addr,
  output logic               W_en,
  output logic [D_WIDTH-1:0] W_Data
`ifdef FIFO_LEVEL_EN
  ,
  output logic [A_WIDTH:0]   Level,
  output logic               Almost_Full
`endif
);
  localparam logic [A_WIDTH:0] DEPTH = (A_WIDTH+1)'(2**A_WIDTH);

  logic [A_WIDTH:0] count, count_nxt;
  fifo_stat_t       stat;
  fifo_hs_t         hs;

  // Status comes only from registered count, so ready/valid never see the opposite side's inputs.
  always_comb begin
    stat.full  = (count == DEPTH);
    stat.empty = (count == '0);
    In_Ready   = !stat.full && !Rst;
    Out_Valid  = !stat.empty && !Rst;
    hs.push    = In_Valid && In_Ready;
    hs.pop     = Out_Valid && Out_Ready;
  end

  assign W_en     = hs.push;
  assign W_Data   = In_Data;
  assign R_en     = Out_Valid;
  assign Out_Data = R_Data;

  fifo_ptr #(.W(A_WIDTH)) u_wr_ptr (.Clk(Clk), .Rst(Rst), .inc(hs.push), .ptr(W_Addr));
  fifo_ptr #(.W(A_WIDTH)) u_rd_ptr (.Clk(Clk), .Rst(Rst), .inc(hs.pop),  .ptr(R_Addr));

  always_comb begin
    count_nxt = count;
    case ({hs.push, hs.pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) count <= '0;
    else     count <= count_nxt;
  end

`ifdef FIFO_LEVEL_EN
  localparam logic [A_WIDTH:0] AF_TH = (A_WIDTH+1)'(AF_LVL);

  // Registered from count_nxt so both track count with no lag.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Level       <= '0;
      Almost_Full <= 1'b0;
    end else begin
      Level       <= count_nxt;
      Almost_Full <= (count_nxt >= AF_TH);
    end
  end
`endif
endmodule
